// File: rtl/cerere_pkg.sv
// Shared definitions for the cerere/grant requester agent: FSM encodings and
// default sizing constants, also used by arbiter-level benches.
package cerere_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_BURST   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam int DEF_LEN_W   = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/cerere_wait_timer.sv
// Counts REQ cycles spent without a grant; expire flags the last cycle
// before the job must be abandoned (never asserted when TIMEOUT is 0).
module cerere_wait_timer #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/cerere_client.sv
// Requester agent for one port of the 2-port round-robin arbiter: requests,
// streams a burst of len beats while granted, then releases for one cycle.
module cerere_client
  import cerere_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             cerere,
  input  logic             grant,
  output logic             data_valid,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output state_e           dbg_state
);

  // Handshake: a beat transfers in every cycle where state is BURST and
  // grant is high; data_valid marks exactly those cycles and nothing else.

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             cerere_q, cerere_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             wait_clr, wait_en, wait_expire;

  cerere_wait_timer #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (wait_clr),
    .en    (wait_en),
    .expire(wait_expire)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    wait_clr   = 1'b0;
    wait_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d    = ST_REQ;
            len_d      = len;
            beat_cnt_d = '0;
            wait_clr   = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // A grant in the limit cycle takes priority over the abort.
        if (grant) begin
          state_d  = ST_BURST;
          wait_clr = 1'b1;
        end else if (wait_expire) begin
          state_d    = ST_IDLE;
          timeout_d  = 1'b1;
          beat_cnt_d = '0;
          wait_clr   = 1'b1;
        end else begin
          wait_en = 1'b1;
        end
      end
      ST_BURST: begin
        if (grant) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (beat_cnt_q == len_q - LEN_W'(1)) begin
            state_d = ST_RELEASE;
            done_d  = 1'b1;
          end
        end else begin
          state_d  = ST_REQ;
          wait_clr = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cerere_d = (state_d == ST_REQ) || (state_d == ST_BURST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
      cerere_q   <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      cerere_q   <= cerere_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign cerere     = cerere_q;
  assign beat_cnt   = beat_cnt_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != ST_IDLE);
  assign data_valid = (state_q == ST_BURST) && grant;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cerere_client.sv
// Directed bench for cerere_client: single client with a bench-driven grant,
// plus two clients sharing a small round-robin arbiter model.
module tb_cerere_client;
  import cerere_pkg::*;

  localparam int LW = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // single client under directed control
  logic          start, grant_drv, tie;
  logic [LW-1:0] len;
  logic          cerere, grant, data_valid, busy, done, timeout;
  logic [LW-1:0] beat_cnt;
  state_e        st;

  assign grant = tie ? cerere : grant_drv;

  cerere_client #(.LEN_W(LW), .TIMEOUT(5), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .cerere(cerere),
    .grant(grant), .data_valid(data_valid), .beat_cnt(beat_cnt), .busy(busy),
    .done(done), .timeout(timeout), .dbg_state(st)
  );

  // two clients on a registered round-robin arbiter
  logic          st_a, st_b, cer_a, cer_b, dv_a, dv_b, busy_a, busy_b;
  logic          done_a, done_b, to_a, to_b;
  logic [LW-1:0] len_a, len_b, bc_a, bc_b;
  state_e        sa, sb;
  logic [1:0]    gnt;
  logic          last;

  cerere_client #(.LEN_W(LW)) u_a (
    .clk(clk), .reset(reset), .start(st_a), .len(len_a), .cerere(cer_a),
    .grant(gnt[0]), .data_valid(dv_a), .beat_cnt(bc_a), .busy(busy_a),
    .done(done_a), .timeout(to_a), .dbg_state(sa)
  );

  cerere_client #(.LEN_W(LW)) u_b (
    .clk(clk), .reset(reset), .start(st_b), .len(len_b), .cerere(cer_b),
    .grant(gnt[1]), .data_valid(dv_b), .beat_cnt(bc_b), .busy(busy_b),
    .done(done_b), .timeout(to_b), .dbg_state(sb)
  );

  always @(posedge clk) begin
    if (reset) begin
      gnt  <= 2'b00;
      last <= 1'b1;
    end else if (gnt[0] && cer_a) begin
      gnt <= 2'b01;
    end else if (gnt[1] && cer_b) begin
      gnt <= 2'b10;
    end else if (cer_a && cer_b) begin
      gnt  <= last ? 2'b01 : 2'b10;
      last <= ~last;
    end else if (cer_a) begin
      gnt  <= 2'b01;
      last <= 1'b0;
    end else if (cer_b) begin
      gnt  <= 2'b10;
      last <= 1'b1;
    end else begin
      gnt <= 2'b00;
    end
  end

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cer_n, to_n, done_n, dva_n, dvb_n, dna_n, dnb_n, ovl_n, fa, fb;

    reset = 1'b1; start = 1'b0; len = '0; tie = 1'b0; grant_drv = 1'b0;
    st_a = 1'b0; st_b = 1'b0; len_a = 4'd2; len_b = 4'd2;
    repeat (10) step();
    chk("rst_state", st, ST_IDLE);
    chk("rst_cerere", cerere, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;

    // normal burst, grant follows cerere
    len = 4'd3; start = 1'b1; tie = 1'b1;
    step(); start = 1'b0; #1;
    chk("nb_c1_state", st, ST_REQ);
    chk("nb_c1_cerere", cerere, 1);
    chk("nb_c1_dv", data_valid, 0);
    step();
    chk("nb_c2_state", st, ST_BURST);
    chk("nb_c2_dv", data_valid, 1);
    chk("nb_c2_beat", beat_cnt, 0);
    step();
    chk("nb_c3_beat", beat_cnt, 1);
    step();
    chk("nb_c4_dv", data_valid, 1);
    chk("nb_c4_beat", beat_cnt, 2);
    step();
    chk("nb_c5_state", st, ST_RELEASE);
    chk("nb_c5_cerere", cerere, 0);
    chk("nb_c5_done", done, 1);
    chk("nb_c5_beat", beat_cnt, 3);
    chk("nb_c5_busy", busy, 1);
    step();
    chk("nb_c6_busy", busy, 0);
    chk("nb_c6_done", done, 0);
    chk("nb_c6_beat", beat_cnt, 3);

    // preemption after beat 2, plus a start that arrives mid-burst
    tie = 1'b0; grant_drv = 1'b1; len = 4'd4; start = 1'b1;
    step(); start = 1'b0; #1;
    chk("pr_c1_state", st, ST_REQ);
    chk("pr_c1_beat", beat_cnt, 0);
    step(); step();
    chk("pr_c3_beat", beat_cnt, 1);
    step(); grant_drv = 1'b0; #1;
    chk("pr_c4_beat", beat_cnt, 2);
    chk("pr_c4_dv", data_valid, 0);
    chk("pr_c4_cerere", cerere, 1);
    step();
    chk("pr_c5_state", st, ST_REQ);
    chk("pr_c5_cerere", cerere, 1);
    chk("pr_c5_beat", beat_cnt, 2);
    chk("pr_c5_dv", data_valid, 0);
    step(); grant_drv = 1'b1; #1;
    chk("pr_c6_state", st, ST_REQ);
    step(); start = 1'b1; len = 4'd9; #1;
    chk("pr_c7_state", st, ST_BURST);
    chk("pr_c7_dv", data_valid, 1);
    step(); start = 1'b0; #1;
    chk("pr_c8_beat", beat_cnt, 3);
    step();
    chk("pr_c9_done", done, 1);
    chk("pr_c9_beat", beat_cnt, 4);
    step();
    chk("pr_c10_state", st, ST_IDLE);
    chk("pr_c10_beat", beat_cnt, 4);

    // timeout with grant never given
    grant_drv = 1'b0; len = 4'd2; start = 1'b1;
    step(); start = 1'b0; #1;
    cer_n = 0; to_n = 0; done_n = 0;
    for (int i = 0; i < 8; i++) begin
      cer_n += int'(cerere);
      to_n += int'(timeout);
      done_n += int'(done);
      if (timeout) begin
        chk("to_busy", busy, 0);
        chk("to_beat", beat_cnt, 0);
        chk("to_cerere", cerere, 0);
      end
      step();
    end
    chk("to_cerere_cycles", cer_n, 5);
    chk("to_pulses", to_n, 1);
    chk("to_no_done", done_n, 0);

    // grant arriving in the limit cycle beats the timeout
    len = 4'd1; start = 1'b1;
    step(); start = 1'b0;
    repeat (3) step();
    step(); grant_drv = 1'b1; #1;
    chk("tb_c5_state", st, ST_REQ);
    step();
    chk("tb_c6_state", st, ST_BURST);
    chk("tb_c6_timeout", timeout, 0);
    chk("tb_c6_dv", data_valid, 1);
    step();
    chk("tb_c7_done", done, 1);
    chk("tb_c7_timeout", timeout, 0);
    chk("tb_c7_beat", beat_cnt, 1);
    step(); grant_drv = 1'b0;

    // zero-length job
    len = 4'd0; start = 1'b1;
    step(); start = 1'b0; #1;
    chk("zl_done", done, 1);
    chk("zl_cerere", cerere, 0);
    chk("zl_busy", busy, 0);
    step();
    chk("zl_done_end", done, 0);
    chk("zl_cerere_end", cerere, 0);

    // reset after the first beat
    tie = 1'b1; len = 4'd3; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    chk("rm_beat_pre", beat_cnt, 1);
    reset = 1'b1;
    step();
    chk("rm_state", st, ST_IDLE);
    chk("rm_cerere", cerere, 0);
    chk("rm_beat", beat_cnt, 0);
    chk("rm_busy", busy, 0);
    chk("rm_done", done, 0);
    chk("rm_dv", data_valid, 0);
    reset = 1'b0;
    step();
    chk("rm_no_done", done, 0);
    tie = 1'b0;

    // two clients through the arbiter, simultaneous starts
    st_a = 1'b1; st_b = 1'b1;
    step(); st_a = 1'b0; st_b = 1'b0; #1;
    dva_n = 0; dvb_n = 0; dna_n = 0; dnb_n = 0; ovl_n = 0; fa = 0; fb = 0;
    for (int c = 1; c <= 20; c++) begin
      dva_n += int'(dv_a);
      dvb_n += int'(dv_b);
      dna_n += int'(done_a);
      dnb_n += int'(done_b);
      ovl_n += int'(dv_a && dv_b);
      if (dv_a && fa == 0) fa = c;
      if (dv_b && fb == 0) fb = c;
      if (done_a) chk("ar_a_release_cerere", cer_a, 0);
      if (done_b) chk("ar_b_release_cerere", cer_b, 0);
      step();
    end
    chk("ar_a_beats", dva_n, 2);
    chk("ar_b_beats", dvb_n, 2);
    chk("ar_a_done", dna_n, 1);
    chk("ar_b_done", dnb_n, 1);
    chk("ar_overlap", ovl_n, 0);
    chk("ar_a_first", fa, 3);
    chk("ar_b_first", fb, 7);
    chk("ar_a_beat_cnt", bc_a, 2);
    chk("ar_b_beat_cnt", bc_b, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cerere_client.md
Name: cerere_client

Overview:
- Requester-side agent for the 2-port round-robin grant arbiter (cerere_x/grant_x interface).
- Accepts a burst job from local logic and raises cerere until granted.
- Once granted, streams len beats, then releases cerere for one cycle so the arbiter can rotate.
- Handles grant loss mid-burst (re-request) and a grant-wait timeout.
- One instance per arbiter port.

Parameters:
- LEN_W, 4: width of len and beat_cnt; maximum burst is 2^LEN_W-1 beats.
- TIMEOUT, 16: number of REQ cycles without grant before abort; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; requires TIMEOUT < 2^CNT_W.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: job strobe; sampled only in IDLE.
- len, input, LEN_W: burst length; latched on an accepted start.
- cerere, output, 1: request to the arbiter.
- grant, input, 1: grant from the arbiter.
- data_valid, output, 1: beat strobe; equals (state==BURST) & grant, combinational from state.
- beat_cnt, output, LEN_W: beats completed in the current job.
- busy, output, 1: high when state != IDLE.
- done, output, 1: one-cycle pulse at job completion.
- timeout, output, 1: one-cycle pulse when a job is aborted on timeout.

Behaviour:
- Reset: state=IDLE; cerere=0, data_valid=0, beat_cnt=0, busy=0, done=0, timeout=0; len_q=0, wait_cnt=0. Reset overrides any state, including mid-burst; no done is produced.
- Registered outputs: cerere, beat_cnt, done, timeout.
- IDLE, start=1, len!=0: latch len_q=len, clear beat_cnt and wait_cnt, go to REQ. cerere=1 from the next cycle.
- IDLE, start=1, len==0: stay in IDLE, pulse done next cycle, never raise cerere.
- start while busy: ignored; no queuing.
- REQ:
  - cerere=1.
  - grant=1 at the edge: go to BURST, clear wait_cnt.
  - grant=0: wait_cnt++.
  - grant=0 with wait_cnt==TIMEOUT-1 (TIMEOUT!=0): drop cerere, pulse timeout, go to IDLE, clear beat_cnt.
  - grant arriving in the limit cycle wins over timeout.
- BURST:
  - cerere=1. Each cycle with grant=1 is one beat: data_valid=1, beat_cnt++ at the edge.
  - Beat with beat_cnt==len_q-1: go to RELEASE.
  - grant=0 in BURST (preemption): no beat, return to REQ, keep beat_cnt, clear wait_cnt.
- RELEASE: cerere=0, done=1 for exactly one cycle, then IDLE. beat_cnt holds len_q until the next accepted start.
- Latency with grant held high: start at edge 0 → REQ in cycle 1 → BURST in cycle 2 → beats in cycles 2..len+1 → RELEASE at len+2 (done=1) → IDLE at len+3.
- cerere never drops while in REQ or BURST, except on timeout or reset.
- grant in IDLE or RELEASE is ignored; data_valid stays 0.
- beat_cnt cannot wrap: the maximum len is 2^LEN_W-1.
- done and timeout are mutually exclusive.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, REQ=2'd1, BURST=2'd2, RELEASE=2'd3) and default LEN_W/TIMEOUT constants, reused by the arbiter bench.
- One sub-module, cerere_wait_timer: CNT_W counter with clear, enable and an expire flag for wait_cnt == TIMEOUT-1.

Test Plan:
- Normal burst: reset 10 cycles; start with len=3; grant tied to cerere after 1 cycle → cerere high 4 cycles, data_valid high 3 cycles, beat_cnt 0→3, done pulse with cerere=0, busy drops 1 cycle later.
- Preemption: len=4; grant drops for 2 cycles after beat 2 → data_valid low for those cycles, state REQ, cerere stays 1, beat_cnt holds 2; resumes to 4 then done.
- Timeout: TIMEOUT=5, grant=0 forever → cerere high exactly 5 cycles, timeout pulse, no done, beat_cnt=0, busy=0.
- Timeout boundary: grant asserted in the 5th REQ cycle → no timeout, burst proceeds.
- Zero length and ignored start: len=0 → done pulse, cerere never 1. start during BURST → ignored, len_q unchanged.
- Reset mid-burst, plus two clients on the arbiter: reset after beat 1 → all outputs 0 next cycle. Two clients on the 2-port arbiter with simultaneous starts, len=2 each → grants alternate, each client sees 2 beats and one done, cerere low for 1 cycle between jobs.
